// File: rtl/fft_1024_bitrev_reorder_if.sv
// Stream bundle for the FFT output reorder stage: bit-reversed input stream,
// natural-order output stream and the resync error strobe.
interface fft_1024_bitrev_reorder_if #(
  parameter int DATA_W = 16
);
  logic              in_sync;
  logic [DATA_W-1:0] in_re;
  logic [DATA_W-1:0] in_im;
  logic              out_sync;
  logic              out_valid;
  logic [DATA_W-1:0] out_re;
  logic [DATA_W-1:0] out_im;
  logic              frame_err;

  modport master (
    output in_sync, in_re, in_im,
    input  out_sync, out_valid, out_re, out_im, frame_err
  );

  modport slave (
    input  in_sync, in_re, in_im,
    output out_sync, out_valid, out_re, out_im, frame_err
  );
endinterface

// File: rtl/fft_1024_bitrev_reorder.sv
// Bit-reversed to natural-order reorder buffer for the 1024-point FFT:
// frames fill one bank of a ping-pong RAM while the other bank streams out.
module fft_1024_bitrev_reorder #(
  parameter int DATA_W = 16,
  parameter int LOG2N  = 10
) (
  input  logic                      clock_c,
  input  logic                      rst_n,
  input  logic                      en,
  fft_1024_bitrev_reorder_if.slave  bus
);
  localparam int N     = 1 << LOG2N;
  localparam int MEM_W = 2 * DATA_W;
  localparam logic [LOG2N-1:0] LAST = {LOG2N{1'b1}};
  localparam logic [LOG2N-1:0] ONE  = LOG2N'(1);

  typedef enum logic { W_IDLE, W_FILL } w_state_t;
  typedef enum logic { R_IDLE, R_READ } r_state_t;

  w_state_t          w_state_reg;
  logic [LOG2N-1:0]  wcnt_reg;
  logic              wbank_reg;
  logic [1:0]        ready_reg;
  logic [1:0]        ready_next;
  logic              frame_err_reg;

  r_state_t          r_state_reg;
  logic [LOG2N-1:0]  rcnt_reg;
  logic              rbank_reg;
  logic              rd_issue_reg;
  logic              rd_first_reg;

  logic [MEM_W-1:0]  mem [0:2*N-1];
  logic [MEM_W-1:0]  mem_q_reg;

  logic              out_sync_reg;
  logic              out_valid_reg;
  logic [DATA_W-1:0] out_re_reg;
  logic [DATA_W-1:0] out_im_reg;

  logic [LOG2N-1:0]  wcnt_rev;
  logic              mem_we;
  logic [LOG2N-1:0]  waddr_lo;
  logic              wr_done;
  logic              rd_start;
  logic              rd_cont;
  logic              rd_sel;
  logic              rd_bank;
  logic [LOG2N-1:0]  raddr_lo;

  genvar gi;
  generate
    for (gi = 0; gi < LOG2N; gi++) begin : g_bitrev
      assign wcnt_rev[gi] = wcnt_reg[LOG2N-1-gi];
    end
  endgenerate

  always_comb begin
    mem_we   = bus.in_sync || (w_state_reg == W_FILL);
    waddr_lo = bus.in_sync ? '0 : wcnt_rev;
    wr_done  = !bus.in_sync && (w_state_reg == W_FILL) && (wcnt_reg == LAST);

    // A finished readout chains straight into the next ready bank with no gap.
    rd_start = ((r_state_reg == R_IDLE) || (rcnt_reg == LAST)) && (|ready_reg);
    rd_cont  = (r_state_reg == R_READ) && (rcnt_reg != LAST);
    rd_sel   = ready_reg[0] ? 1'b0 : 1'b1;
    rd_bank  = rd_start ? rd_sel : rbank_reg;
    raddr_lo = rd_start ? '0 : (rcnt_reg + ONE);

    ready_next = ready_reg;
    if (rd_start) ready_next[rd_sel] = 1'b0;
    if (wr_done)  ready_next[wbank_reg] = 1'b1;
  end

  // Storage has no reset; the read register is only consumed behind rd_issue_reg.
  always_ff @(posedge clock_c) begin
    if (en && rst_n && mem_we)
      mem[{wbank_reg, waddr_lo}] <= {bus.in_re, bus.in_im};
    if (en)
      mem_q_reg <= mem[{rd_bank, raddr_lo}];
  end

  always_ff @(posedge clock_c) begin
    if (!rst_n) begin
      w_state_reg   <= W_IDLE;
      wcnt_reg      <= '0;
      wbank_reg     <= 1'b0;
      ready_reg     <= 2'b00;
      frame_err_reg <= 1'b0;
    end else if (en) begin
      ready_reg     <= ready_next;
      frame_err_reg <= 1'b0;
      if (bus.in_sync) begin
        // A sync while filling abandons the partial frame in the same bank.
        if (w_state_reg == W_FILL)
          frame_err_reg <= 1'b1;
        wcnt_reg    <= ONE;
        w_state_reg <= W_FILL;
      end else if (w_state_reg == W_FILL) begin
        if (wcnt_reg == LAST) begin
          wcnt_reg    <= '0;
          wbank_reg   <= ~wbank_reg;
          w_state_reg <= W_IDLE;
        end else begin
          wcnt_reg <= wcnt_reg + ONE;
        end
      end
    end
  end

  always_ff @(posedge clock_c) begin
    if (!rst_n) begin
      r_state_reg  <= R_IDLE;
      rcnt_reg     <= '0;
      rbank_reg    <= 1'b0;
      rd_issue_reg <= 1'b0;
      rd_first_reg <= 1'b0;
    end else if (en) begin
      rd_issue_reg <= rd_start || rd_cont;
      rd_first_reg <= rd_start;
      if (rd_start) begin
        rbank_reg   <= rd_sel;
        rcnt_reg    <= '0;
        r_state_reg <= R_READ;
      end else if (rd_cont) begin
        rcnt_reg <= rcnt_reg + ONE;
      end else begin
        rcnt_reg    <= '0;
        r_state_reg <= R_IDLE;
      end
    end
  end

  always_ff @(posedge clock_c) begin
    if (!rst_n) begin
      out_sync_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
      out_re_reg    <= '0;
      out_im_reg    <= '0;
    end else if (en) begin
      out_valid_reg <= rd_issue_reg;
      out_sync_reg  <= rd_issue_reg && rd_first_reg;
      if (rd_issue_reg) begin
        out_re_reg <= mem_q_reg[MEM_W-1:DATA_W];
        out_im_reg <= mem_q_reg[DATA_W-1:0];
      end
    end
  end

  assign bus.out_sync  = out_sync_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_re    = out_re_reg;
  assign bus.out_im    = out_im_reg;
  assign bus.frame_err = frame_err_reg;
endmodule
